// File: rtl/serial_pkg.sv
// Shared definitions for the mode-1 serial transmitter and the future receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int BAUD_DIV_SMOD0 = 32;
  localparam int BAUD_DIV_SMOD1 = 16;
  localparam int FRAME_BITS     = 10;
  localparam int DIV_CNT_W      = 5;

  // Last count value of the baud divider for the selected SMOD setting.
  function automatic logic [DIV_CNT_W-1:0] div_limit(input logic smod);
    return smod ? DIV_CNT_W'(BAUD_DIV_SMOD1 - 1) : DIV_CNT_W'(BAUD_DIV_SMOD0 - 1);
  endfunction

endpackage

// File: rtl/baud_tick_div.sv
// Turns Timer-1 overflow edges into bit-period boundaries (divide by 16 or 32).
module baud_tick_div
  import serial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tf1,
  input  logic smod_q,
  input  logic clr,
  output logic bit_end
);

  logic                 tf1_q;
  logic                 tick;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic [DIV_CNT_W-1:0] limit;

  assign tick    = tf1 & ~tf1_q;
  assign limit   = div_limit(smod_q);
  assign bit_end = tick & (div_cnt >= limit) & ~clr;

  // A clear restarts the bit period and swallows a coincident tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tf1_q   <= 1'b0;
      div_cnt <= '0;
    end else begin
      tf1_q <= tf1;
      if (clr) begin
        div_cnt <= '0;
      end else if (tick) begin
        if (div_cnt >= limit) begin
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/serial_tx_mode1.sv
// 8051-style mode-1 transmitter: 8-N-1 frames paced by Timer-1 overflows.
module serial_tx_mode1
  import serial_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tf1,
  input  logic              smod,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              ti,
  input  logic              ti_clr
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_START = 2'(START);
  localparam logic [1:0] S_DATA  = 2'(DATA);
  localparam logic [1:0] S_STOP  = 2'(STOP);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              smod_q;
  logic              accept;
  logic              bit_end;
  logic              last_data_end;

  assign tx_ready      = (state == S_IDLE);
  assign accept        = tx_valid & tx_ready;
  assign last_data_end = (state == S_DATA) & bit_end & (bit_idx == LAST_IDX);

  baud_tick_div u_div (
    .clk     (clk),
    .rst     (rst),
    .tf1     (tf1),
    .smod_q  (smod_q),
    .clr     (accept),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)        state_nxt = S_START;
      S_START: if (bit_end)       state_nxt = S_DATA;
      S_DATA:  if (last_data_end) state_nxt = S_STOP;
      S_STOP:  if (bit_end)       state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Line level is decoded from state so reset drives it high without waiting for a clock.
  always_comb begin
    txd = 1'b1;
    case (state)
      S_START: txd = 1'b0;
      S_DATA:  txd = shreg[0];
      default: txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      smod_q  <= 1'b0;
    end else if (accept) begin
      shreg   <= tx_data;
      bit_idx <= '0;
      smod_q  <= smod;
    end else if ((state == S_DATA) && bit_end) begin
      shreg   <= {1'b0, shreg[DATA_W-1:1]};
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  // Setting wins over a same-cycle clear so a completion is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ti <= 1'b0;
    end else if (last_data_end) begin
      ti <= 1'b1;
    end else if (ti_clr) begin
      ti <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tx_mode1.sv
// Randomized bench for serial_tx_mode1 with a tick-counting frame model.
module tb_serial_tx_mode1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tf1 = 1'b0;
  logic       smod = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ti_clr = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       ti;

  int vectors = 0;
  int miscompares = 0;
  int tf1_mode = 0;
  int cyc = 0;

  logic       m_active = 1'b0;
  logic       m_ti = 1'b0;
  logic       m_prev_tf1 = 1'b0;
  logic       m_tick;
  logic       m_set_ti;
  int         m_ticks = 0;
  int         m_div = 16;
  logic [9:0] m_frame = 10'h3FF;

  always #5 clk = ~clk;

  serial_tx_mode1 #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .tf1      (tf1),
    .smod     (smod),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .ti       (ti),
    .ti_clr   (ti_clr)
  );

  // Timer-1 overflow pattern: short pulse every 4 clocks, or 20 high / 20 low.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (tf1_mode == 0) tf1 = ((cyc % 4) == 0);
    else               tf1 = ((cyc % 40) < 20);
  end

  // Model: a frame is 10 bits of m_div ticks each, indexed by ticks counted since accept.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_active   = 1'b0;
      m_ti       = 1'b0;
      m_prev_tf1 = 1'b0;
      m_ticks    = 0;
    end else begin
      m_tick     = tf1 && !m_prev_tf1;
      m_prev_tf1 = tf1;
      m_set_ti   = 1'b0;
      if (!m_active) begin
        if (tx_valid) begin
          m_active = 1'b1;
          m_ticks  = 0;
          m_div    = smod ? 16 : 32;
          m_frame  = {1'b1, tx_data, 1'b0};
        end
      end else if (m_tick) begin
        m_ticks++;
        if (m_ticks == 9 * m_div)  m_set_ti = 1'b1;
        if (m_ticks == 10 * m_div) m_active = 1'b0;
      end
      if (m_set_ti)    m_ti = 1'b1;
      else if (ti_clr) m_ti = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  initial forever begin
    @(negedge clk);
    checkOutput("model_txd", txd, m_active ? m_frame[m_ticks / m_div] : 1'b1);
    checkOutput("model_ready", tx_ready, !m_active);
    checkOutput("model_ti", ti, m_ti);
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raises tx_valid and returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [7:0] data, input logic s, input logic keep);
    int guard = 0;
    @(negedge clk);
    tx_data  = data;
    smod     = s;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) timeoutFail("handshake");
    @(posedge clk);
    #1;
    if (!keep) tx_valid = 1'b0;
  endtask

  // Samples the line mid-bit; bits[0] is the start bit, bits[9] the stop bit.
  task automatic checkFrame(input string name, input logic [9:0] bits, input int bitclk);
    @(negedge clk);
    checkOutput({name, "_start_edge"}, txd, 1'b0);
    checkOutput({name, "_busy"}, tx_ready, 1'b0);
    repeat (bitclk / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("%s_bit%0d", name, i), txd, bits[i]);
      if (i == 9) checkOutput({name, "_ti_in_stop"}, ti, 1'b1);
      else        repeat (bitclk) @(negedge clk);
    end
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while (tx_ready !== 1'b1 && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) timeoutFail(name);
  endtask

  initial begin
    int guard;
    logic [7:0] b;
    logic s;

    waitCycles(3);
    checkOutput("reset_txd", txd, 1'b1);
    checkOutput("reset_ready", tx_ready, 1'b1);
    checkOutput("reset_ti", ti, 1'b0);
    rst = 1'b1;
    waitCycles(5);

    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkFrame("a5_smod1", 10'b1101001010, 64);
    waitIdle("a5_idle");

    @(negedge clk) ti_clr = 1'b1;
    @(negedge clk) ti_clr = 1'b0;
    checkOutput("ti_cleared", ti, 1'b0);

    applyStimulus(8'h3C, 1'b0, 1'b0);
    fork
      checkFrame("3c_smod0", 10'b1001111000, 128);
      begin
        waitCycles(300); smod = 1'b1;
        waitCycles(300); smod = 1'b0;
        waitCycles(100); smod = 1'b1;
      end
    join
    waitIdle("3c_idle");

    @(negedge clk) ti_clr = 1'b1;
    @(negedge clk) ti_clr = 1'b0;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    waitCycles(8 * 64 + 32);
    checkOutput("tiset_bit7_low", txd, 1'b0);
    ti_clr = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (txd !== 1'b1 && guard < 200);
    if (guard >= 200) timeoutFail("tiset_stop");
    checkOutput("ti_set_wins", ti, 1'b1);
    @(negedge clk);
    checkOutput("ti_clear_next", ti, 1'b0);
    ti_clr = 1'b0;
    waitIdle("tiset_idle");

    tf1_mode = 1;
    applyStimulus(8'hC3, 1'b1, 1'b0);
    checkFrame("c3_slow", 10'b1110000110, 640);
    waitIdle("c3_idle");
    tf1_mode = 0;

    applyStimulus(8'h5A, 1'b1, 1'b1);
    fork
      checkFrame("5a_hold", 10'b1010110100, 64);
      repeat (560) begin
        @(negedge clk);
        tx_data = 8'($urandom);
      end
    join
    tx_valid = 1'b0;
    waitIdle("5a_idle");

    applyStimulus(8'h00, 1'b1, 1'b1);
    tx_data = 8'hFF;
    waitCycles(2);
    waitIdle("b2b_gap");
    checkOutput("b2b_gap_high", txd, 1'b1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    checkFrame("b2b_ff", 10'b1111111110, 64);
    waitIdle("b2b_idle");

    applyStimulus(8'h81, 1'b1, 1'b0);
    waitCycles(288);
    checkOutput("pre_reset_bit3", txd, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_txd", txd, 1'b1);
    checkOutput("async_reset_ready", tx_ready, 1'b1);
    checkOutput("async_reset_ti", ti, 1'b0);
    waitCycles(3);
    rst = 1'b1;
    waitCycles(2);
    applyStimulus(8'h81, 1'b1, 1'b0);
    checkFrame("81_after_reset", 10'b1100000010, 64);
    waitIdle("81_idle");

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      applyStimulus(b, s, 1'b0);
      fork
        waitIdle("rand_idle");
        repeat (2) begin
          waitCycles($urandom_range(20, 500));
          ti_clr = 1'b1;
          @(negedge clk) ti_clr = 1'b0;
        end
      join
      waitCycles($urandom_range(0, 6));
    end

    waitCycles(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/serial_tx_mode1.md
# serial_tx_mode1

Mode-1 asynchronous serial transmitter (8-N-1 framing), the consumer end of the Timer-1 baud generator. It converts the timer's TF1 overflow flag into bit-rate ticks through a ÷16/÷32 divider selected by SMOD. It accepts bytes over a valid/ready handshake, shifts them out LSB-first on `txd`, and raises a sticky `ti` completion flag with 8051 serial-port semantics.

## Interface
Parameters:
- `DATA_W`, 8, data bits per frame (fixed 8 for mode 1; parameterised for the shift register only)

Ports:
- `clk`  input  1  system clock; one clock domain, all logic rising-edge
- `rst`  input  1  asynchronous, active-low reset
- `tf1`  input  1  Timer-1 overflow flag (level); each 0→1 transition is one baud tick
- `smod`  input  1  0: bit = 32 ticks, 1: bit = 16 ticks; sampled at frame accept
- `tx_data`  input  8  byte to send
- `tx_valid`  input  1  byte request
- `tx_ready`  output  1  high only in IDLE; transfer when `tx_valid && tx_ready`
- `txd`  output  1  serial line, idle high
- `ti`  output  1  transmit-interrupt flag, sticky
- `ti_clr`  input  1  one-cycle clear of `ti`

## Operation
- Tick: `tf1_q` registers `tf1`; `tick = tf1 & ~tf1_q`. A `tf1` held high for many cycles produces one tick.
- Divider: 5-bit `div_cnt`; limit `DIV-1` with DIV = 16 (smod_q=1) or 32 (smod_q=0). It increments on tick. On tick at limit it wraps to 0 and emits `bit_end`.
- States: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1, `tx_ready`=1. On handshake, latch `tx_data` into `shreg` and `smod` into `smod_q`; clear `div_cnt` and `bit_idx`; go START.
  - START: `txd`=0. On `bit_end`, go DATA.
  - DATA: `txd`=`shreg[0]`. On `bit_end`, shift right and increment `bit_idx`; after bit 7 (`bit_idx`=7), go STOP.
  - STOP: `txd`=1. On `bit_end`, go IDLE.
- `ti`: set on the cycle of the DATA→STOP transition, so it is high from the first cycle of the stop bit. It clears on `ti_clr`. If set and clear fall in the same cycle, set wins. `ti` does not gate new transfers.
- `tx_valid` outside IDLE is ignored. `tx_data` is sampled only at the handshake.
- Reset values: `txd`=1, `tx_ready`=1, `ti`=0, state IDLE, `div_cnt`=0, `bit_idx`=0, `tf1_q`=0. Reset asserted mid-frame aborts the frame immediately, with `txd` high asynchronously.

## Timing
- Handshake at cycle N: `txd` falls at N+1, `tx_ready` low at N+1.
- Each of start, 8 data, and stop bits lasts exactly DIV ticks. The start bit also includes the partial tick interval before the first tick.
- A frame ends on the cycle of the last stop `bit_end`. `tx_ready` is high the next cycle, and a back-to-back handshake there gives no idle gap beyond that cycle.
- A tick and a state change in the same cycle: the state update uses that tick, with no lost or double count.
- `smod` changes mid-frame have no effect until the next accept.

## Structure
- Package `serial_pkg`: state enum `tx_state_t` {IDLE, START, DATA, STOP}; constants `BAUD_DIV_SMOD0`=32, `BAUD_DIV_SMOD1`=16, `FRAME_BITS`=10. The future receiver shares this package.
- Sub-module `baud_tick_div`: `tf1` edge detect plus the ÷16/÷32 counter. Inputs: `clk`, `rst`, `tf1`, `smod_q`, `clr`. Output: `bit_end`. It is reused by the receiver with a ÷16 sample-point tap.
- Top: FSM, shift register, `bit_idx`, `ti` logic.

## Test plan
Bench drives a `tf1` pulse (1 cycle) every 4 clocks unless stated.
- Reset → `txd`=1, `tx_ready`=1, `ti`=0. Send 0xA5 with `smod`=1 → `txd` bit sequence 0,1,0,1,0,0,1,0,1,1, each 16 ticks (64 clk). `ti` rises at stop-bit start. `tx_ready` returns after stop.
- 0x3C with `smod`=0 → each bit 32 ticks (128 clk). Toggle `smod` mid-frame → no change in bit width.
- `tf1` held high 20 cycles per pulse, period 40 → one tick per pulse, bit = 16×40 clk with `smod`=1.
- `tx_valid` asserted throughout a frame with changing `tx_data` → only the first byte is sent. Back-to-back 0x00, 0xFF → second start bit begins 1 cycle after the first stop bit ends.
- `ti_clr` pulsed on the exact cycle `ti` sets → `ti`=1. `ti_clr` one cycle later → `ti`=0.
- `rst` low during data bit 3 → `txd`=1 within the same cycle, `tx_ready`=1. After release, a new 0x81 frame is correct.
